// File: rtl/mc_dst_list_builder.sv
// Folds serial destination IDs into a one-hot multicast list; last ID -> out_valid next cycle.
// Input is back-pressured (in_ready=0) while a completed list waits for out_ready.
module mc_dst_list_builder #(
    parameter int DST_LIST_WIDTH = 64,
    parameter int NODE_ID_WIDTH  = 6,
    parameter int CNT_WIDTH      = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NODE_ID_WIDTH-1:0]  my_id,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NODE_ID_WIDTH-1:0]  in_dst_id,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DST_LIST_WIDTH-1:0] out_dst_list,
    output logic [CNT_WIDTH-1:0]      out_dst_count,
    output logic                      out_self,
    output logic                      dup_pulse,
    output logic                      range_err,
    output logic                      empty_pulse
);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    localparam logic [31:0] LIST_W = 32'(DST_LIST_WIDTH);

    state_t                    state, state_nxt;
    logic [DST_LIST_WIDTH-1:0] list_nxt, dst_onehot;
    logic [CNT_WIDTH-1:0]      count_nxt;
    logic                      self_nxt, self_clr, self_clr_nxt;
    logic                      dup_nxt, range_nxt, empty_nxt;
    logic                      accept, in_range, is_self, is_dup;

    assign in_ready   = (state != EMIT);
    assign out_valid  = (state == EMIT);
    assign accept     = in_valid & in_ready;
    assign in_range   = (32'(in_dst_id) < LIST_W);
    assign dst_onehot = {{(DST_LIST_WIDTH-1){1'b0}}, 1'b1} << in_dst_id;
    assign is_self    = (in_dst_id == my_id);
    assign is_dup     = |(out_dst_list & dst_onehot);

    always_comb begin
        state_nxt    = state;
        list_nxt     = out_dst_list;
        count_nxt    = out_dst_count;
        // self survives exactly one cycle after an empty close so the NI can see it
        self_nxt     = self_clr ? 1'b0 : out_self;
        self_clr_nxt = 1'b0;
        dup_nxt      = 1'b0;
        range_nxt    = 1'b0;
        empty_nxt    = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (accept) begin
                    if (!in_range) begin
                        range_nxt = 1'b1;
                    end else if (is_self) begin
                        self_nxt = 1'b1;
                    end else if (is_dup) begin
                        dup_nxt = 1'b1;
                    end else begin
                        list_nxt  = out_dst_list | dst_onehot;
                        count_nxt = out_dst_count + CNT_WIDTH'(1);
                    end
                    if (!in_last) begin
                        state_nxt = COLLECT;
                    end else if (count_nxt == '0) begin
                        state_nxt    = IDLE;
                        empty_nxt    = 1'b1;
                        self_clr_nxt = 1'b1;
                    end else begin
                        state_nxt = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    list_nxt  = '0;
                    count_nxt = '0;
                    self_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            out_dst_list  <= '0;
            out_dst_count <= '0;
            out_self      <= 1'b0;
            self_clr      <= 1'b0;
            dup_pulse     <= 1'b0;
            range_err     <= 1'b0;
            empty_pulse   <= 1'b0;
        end else begin
            state         <= state_nxt;
            out_dst_list  <= list_nxt;
            out_dst_count <= count_nxt;
            out_self      <= self_nxt;
            self_clr      <= self_clr_nxt;
            dup_pulse     <= dup_nxt;
            range_err     <= range_nxt;
            empty_pulse   <= empty_nxt;
        end
    end

endmodule

// File: tb/tb_mc_dst_list_builder.sv
// Directed bench for mc_dst_list_builder: a 64-node instance plus a 48-node instance for range errors.
module tb_mc_dst_list_builder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  my_id;
    logic        in_valid, in_last, out_ready;
    logic [5:0]  in_dst_id;
    logic        in_ready, out_valid, out_self, dup_pulse, range_err, empty_pulse;
    logic [63:0] out_dst_list;
    logic [6:0]  out_dst_count;

    logic        b_in_valid, b_in_last, b_out_ready;
    logic [5:0]  b_in_dst_id;
    logic        b_in_ready, b_out_valid, b_out_self, b_dup_pulse, b_range_err, b_empty_pulse;
    logic [47:0] b_out_dst_list;
    logic [6:0]  b_out_dst_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_dst_list_builder u_dut (
        .clk(clk), .rst_n(rst_n), .my_id(my_id),
        .in_valid(in_valid), .in_ready(in_ready), .in_dst_id(in_dst_id), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_dst_list(out_dst_list),
        .out_dst_count(out_dst_count), .out_self(out_self), .dup_pulse(dup_pulse),
        .range_err(range_err), .empty_pulse(empty_pulse)
    );

    mc_dst_list_builder #(.DST_LIST_WIDTH(48), .NODE_ID_WIDTH(6), .CNT_WIDTH(7)) u_dut48 (
        .clk(clk), .rst_n(rst_n), .my_id(my_id),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_dst_id(b_in_dst_id), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_dst_list(b_out_dst_list),
        .out_dst_count(b_out_dst_count), .out_self(b_out_self), .dup_pulse(b_dup_pulse),
        .range_err(b_range_err), .empty_pulse(b_empty_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] id, input logic last);
        chk("push_rdy", {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        in_dst_id = id;
        in_last   = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push48(input logic [5:0] id, input logic last);
        b_in_valid  = 1'b1;
        b_in_dst_id = id;
        b_in_last   = last;
        step();
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; my_id = 6'd5;
        in_valid = 1'b0; in_last = 1'b0; in_dst_id = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_last = 1'b0; b_in_dst_id = '0; b_out_ready = 1'b1;
        #12;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_list", out_dst_list, 64'd0);
        chk("rst_count", {57'd0, out_dst_count}, 64'd0);
        chk("rst_pulses", {61'd0, out_self, dup_pulse, range_err, empty_pulse}, 64'd0);
        rst_n = 1'b1;
        step();

        // 1: basic packet, outputs one cycle after last
        out_ready = 1'b1;
        push(6'd3, 1'b0);
        push(6'd9, 1'b0);
        chk("t1_partial", out_dst_list, 64'h0000_0000_0000_0208);
        chk("t1_novalid", {63'd0, out_valid}, 64'd0);
        push(6'd63, 1'b1);
        chk("t1_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_list", out_dst_list, 64'h8000_0000_0000_0208);
        chk("t1_count", {57'd0, out_dst_count}, 64'd3);
        chk("t1_self", {63'd0, out_self}, 64'd0);
        chk("t1_busy", {63'd0, in_ready}, 64'd0);
        step();
        chk("t1_idle_valid", {63'd0, out_valid}, 64'd0);
        chk("t1_cleared", out_dst_list, 64'd0);
        chk("t1_cnt_clr", {57'd0, out_dst_count}, 64'd0);

        // 2: duplicate ID
        push(6'd7, 1'b0);
        chk("t2_nodup", {63'd0, dup_pulse}, 64'd0);
        push(6'd7, 1'b0);
        chk("t2_dup", {63'd0, dup_pulse}, 64'd1);
        push(6'd12, 1'b1);
        chk("t2_dup_once", {63'd0, dup_pulse}, 64'd0);
        chk("t2_list", out_dst_list, 64'h0000_0000_0000_1080);
        chk("t2_count", {57'd0, out_dst_count}, 64'd2);
        step();

        // 3: self requests, then a self-only packet closes empty
        push(6'd5, 1'b0);
        chk("t3_self_acc", {63'd0, out_self}, 64'd1);
        push(6'd20, 1'b1);
        chk("t3_valid", {63'd0, out_valid}, 64'd1);
        chk("t3_list", out_dst_list, 64'h0000_0000_0010_0000);
        chk("t3_count", {57'd0, out_dst_count}, 64'd1);
        chk("t3_self", {63'd0, out_self}, 64'd1);
        step();
        chk("t3_self_clr", {63'd0, out_self}, 64'd0);
        push(6'd5, 1'b1);
        chk("t3_empty", {63'd0, empty_pulse}, 64'd1);
        chk("t3_empty_self", {63'd0, out_self}, 64'd1);
        chk("t3_empty_novld", {63'd0, out_valid}, 64'd0);
        chk("t3_empty_list", out_dst_list, 64'd0);
        step();
        chk("t3_empty_once", {63'd0, empty_pulse}, 64'd0);
        chk("t3_self_gone", {63'd0, out_self}, 64'd0);

        // 5: consumer stalls 4 cycles while source keeps offering
        out_ready = 1'b0;
        push(6'd1, 1'b0);
        push(6'd2, 1'b1);
        in_valid = 1'b1; in_dst_id = 6'd40; in_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_valid", {63'd0, out_valid}, 64'd1);
            chk("t5_bp", {63'd0, in_ready}, 64'd0);
            chk("t5_list", out_dst_list, 64'h6);
            chk("t5_count", {57'd0, out_dst_count}, 64'd2);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("t5_hs_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_hs_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("t5_next_valid", {63'd0, out_valid}, 64'd1);
        chk("t5_next_list", out_dst_list, 64'h0000_0100_0000_0000);
        chk("t5_next_count", {57'd0, out_dst_count}, 64'd1);
        step();

        // 6: reset mid-collect
        push(6'd10, 1'b0);
        push(6'd11, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_list", out_dst_list, 64'd0);
        chk("t6_count", {57'd0, out_dst_count}, 64'd0);
        chk("t6_ready", {63'd0, in_ready}, 64'd1);
        chk("t6_flags", {60'd0, out_valid, dup_pulse, range_err, empty_pulse}, 64'd0);
        #1;
        rst_n = 1'b1;
        step();
        chk("t6_quiet", {59'd0, out_valid, out_self, dup_pulse, range_err, empty_pulse}, 64'd0);
        push(6'd1, 1'b1);
        chk("t6_valid", {63'd0, out_valid}, 64'd1);
        chk("t6_list1", out_dst_list, 64'h2);
        chk("t6_count1", {57'd0, out_dst_count}, 64'd1);
        step();

        // 4: 48-node instance, out-of-range IDs
        push48(6'd50, 1'b0);
        chk("t4_rerr", {63'd0, b_range_err}, 64'd1);
        chk("t4_rerr_list", {16'd0, b_out_dst_list}, 64'd0);
        push48(6'd2, 1'b1);
        chk("t4_rerr_once", {63'd0, b_range_err}, 64'd0);
        chk("t4_valid", {63'd0, b_out_valid}, 64'd1);
        chk("t4_list", {16'd0, b_out_dst_list}, 64'h4);
        chk("t4_count", {57'd0, b_out_dst_count}, 64'd1);
        step();
        push48(6'd47, 1'b1);
        chk("t4_top_list", {16'd0, b_out_dst_list}, 64'h0000_8000_0000_0000);
        chk("t4_top_rerr", {63'd0, b_range_err}, 64'd0);
        step();
        push48(6'd48, 1'b1);
        chk("t4_edge_rerr", {63'd0, b_range_err}, 64'd1);
        chk("t4_edge_empty", {63'd0, b_empty_pulse}, 64'd1);
        chk("t4_edge_novld", {63'd0, b_out_valid}, 64'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
